// File: rtl/sobel_mode_ctrl.sv
// Frame-synchronous mode controller and output selector for the camera-to-VGA filter chain.
// Mode changes take effect only at frame boundaries; Sobel entry is muted while line buffers refill.
module sobel_mode_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SOBEL_LAT   = 2,
  parameter int MUTE_FRAMES = 1,
  parameter int TH_DEFAULT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_mode,
  input  logic [7:0] cfg_thresh,
  input  logic       de_in,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  input  logic       sobel_de,
  input  logic [3:0] sobel_r,
  input  logic [3:0] sobel_g,
  input  logic [3:0] sobel_b,
  output logic [1:0] mode_active,
  output logic [7:0] th_edge,
  output logic       busy,
  output logic       de_out,
  output logic [3:0] r_out,
  output logic [3:0] g_out,
  output logic [3:0] b_out,
  output logic [1:0] dbg_state,
  output logic [1:0] dbg_pend_mode
);

  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, MUTE = 2'd2} state_t;

  localparam logic [1:0] M_BYPASS = 2'd0;
  localparam logic [1:0] M_GRAY   = 2'd1;
  localparam logic [1:0] M_SOBEL  = 2'd2;
  localparam logic [1:0] MUTE_INIT = 2'(MUTE_FRAMES);

  typedef struct packed {
    logic       de;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [1:0] mode;
    logic       mute;
  } pipe_t;

  state_t     state, state_nx;
  logic [1:0] pend_mode, pend_mode_nx;
  logic [7:0] pend_th, pend_th_nx;
  logic [1:0] mode_nx;
  logic [7:0] th_nx;
  logic [1:0] mute_cnt, mute_cnt_nx;
  logic       btn_prev;

  logic       frame_end, cfg_acc, btn_req, req;
  logic [1:0] btn_base, req_mode;
  logic [7:0] req_th;

  // Handshake: a config request transfers on any rising clk edge where cfg_valid && cfg_ready.
  assign cfg_ready     = (state != MUTE);
  assign busy          = (state != RUN);
  assign dbg_state     = state;
  assign dbg_pend_mode = pend_mode;

  assign frame_end = de_in && (x_in == 10'(H_RES - 1)) && (y_in == 10'(V_RES - 1));

  always_comb begin
    cfg_acc  = cfg_valid && cfg_ready;
    btn_req  = btn_mode && !btn_prev && (state != MUTE) && !cfg_acc;
    req      = cfg_acc || btn_req;
    btn_base = (state == PEND) ? pend_mode : mode_active;
    if (cfg_acc) begin
      req_mode = (cfg_mode == 2'd3) ? M_BYPASS : cfg_mode;
      req_th   = cfg_thresh;
    end else begin
      req_mode = (btn_base == M_SOBEL) ? M_BYPASS : btn_base + 2'd1;
      req_th   = th_edge;
    end
  end

  always_comb begin
    state_nx     = state;
    pend_mode_nx = pend_mode;
    pend_th_nx   = pend_th;
    mode_nx      = mode_active;
    th_nx        = th_edge;
    mute_cnt_nx  = mute_cnt;
    case (state)
      RUN: begin
        if (req) begin
          pend_mode_nx = req_mode;
          pend_th_nx   = req_th;
          state_nx     = PEND;
        end
      end
      PEND: begin
        if (frame_end) begin
          mode_nx = pend_mode;
          th_nx   = pend_th;
          // A request landing on frame_end waits for the next frame.
          if (req) begin
            pend_mode_nx = req_mode;
            pend_th_nx   = req_th;
          end else if (pend_mode == M_SOBEL && mode_active != M_SOBEL) begin
            mute_cnt_nx = MUTE_INIT;
            state_nx    = MUTE;
          end else begin
            state_nx = RUN;
          end
        end else if (req) begin
          pend_mode_nx = req_mode;
          pend_th_nx   = req_th;
        end
      end
      MUTE: begin
        if (frame_end) begin
          mute_cnt_nx = mute_cnt - 2'd1;
          if (mute_cnt <= 2'd1) state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pend_mode   <= M_BYPASS;
      pend_th     <= 8'(TH_DEFAULT);
      mode_active <= M_BYPASS;
      th_edge     <= 8'(TH_DEFAULT);
      mute_cnt    <= 2'd0;
      btn_prev    <= 1'b0;
    end else begin
      state       <= state_nx;
      pend_mode   <= pend_mode_nx;
      pend_th     <= pend_th_nx;
      mode_active <= mode_nx;
      th_edge     <= th_nx;
      mute_cnt    <= mute_cnt_nx;
      btn_prev    <= btn_mode;
    end
  end

  // Raw pixel, mode and mute travel together so the select flips exactly at the frame edge.
  pipe_t pipe [SOBEL_LAT];
  pipe_t dly;
  logic [5:0] gsum;
  logic [3:0] g4;
  logic       de_nx;
  logic [3:0] r_nx, g_nx, b_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SOBEL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {de_in, r_in, g_in, b_in, mode_active, state == MUTE};
      for (int i = 1; i < SOBEL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dly  = pipe[SOBEL_LAT-1];
  assign gsum = {2'b00, dly.r} + {1'b0, dly.g, 1'b0} + {2'b00, dly.b};
  assign g4   = 4'(gsum >> 2);

  always_comb begin
    de_nx = dly.de;
    r_nx  = 4'd0;
    g_nx  = 4'd0;
    b_nx  = 4'd0;
    if (dly.de && !dly.mute) begin
      case (dly.mode)
        M_GRAY: begin
          r_nx = g4;
          g_nx = g4;
          b_nx = g4;
        end
        M_SOBEL: begin
          if (sobel_de) begin
            r_nx = sobel_r;
            g_nx = sobel_g;
            b_nx = sobel_b;
          end
        end
        default: begin
          r_nx = dly.r;
          g_nx = dly.g;
          b_nx = dly.b;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_out <= 1'b0;
      r_out  <= 4'd0;
      g_out  <= 4'd0;
      b_out  <= 4'd0;
    end else begin
      de_out <= de_nx;
      r_out  <= r_nx;
      g_out  <= g_nx;
      b_out  <= b_nx;
    end
  end

endmodule

// File: tb/tb_sobel_mode_ctrl.sv
// Bench for sobel_mode_ctrl: small frame geometry, table of config requests plus hand-written
// sequences for button, same-cycle and reset corner cases; pixels checked through an expected queue.
module tb_sobel_mode_ctrl;

  localparam int H = 8;
  localparam int V = 4;
  localparam int LAT = 2;
  localparam int MF = 1;
  localparam int TH = 16;
  localparam int LINE_CYC = H + 4;
  localparam int FRAME_CYC = (V + 1) * LINE_CYC;

  logic       clk, reset;
  logic       btn_mode, cfg_valid, cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_thresh;
  logic       de_in;
  logic [9:0] x_in, y_in;
  logic [3:0] r_in, g_in, b_in;
  logic       sobel_de;
  logic [3:0] sobel_r, sobel_g, sobel_b;
  logic [1:0] mode_active;
  logic [7:0] th_edge;
  logic       busy, de_out;
  logic [3:0] r_out, g_out, b_out;
  logic [1:0] dbg_state, dbg_pend_mode;

  sobel_mode_ctrl #(
    .H_RES(H), .V_RES(V), .SOBEL_LAT(LAT), .MUTE_FRAMES(MF), .TH_DEFAULT(TH)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .de_in(de_in), .x_in(x_in), .y_in(y_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .sobel_de(sobel_de), .sobel_r(sobel_r), .sobel_g(sobel_g), .sobel_b(sobel_b),
    .mode_active(mode_active), .th_edge(th_edge), .busy(busy),
    .de_out(de_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .dbg_state(dbg_state), .dbg_pend_mode(dbg_pend_mode)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       de;
    logic [9:0] x;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } raw_t;

  logic [12:0] exp_q[$];
  raw_t        hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard model of the final pixel
  function automatic logic [12:0] exp_pix(input logic [1:0] mode, input logic mute, input raw_t p);
    int s;
    logic [3:0] gv;
    if (!p.de) return 13'h0;
    if (mute) return {1'b1, 12'h0};
    case (mode)
      2'd1: begin
        s  = int'(p.r) + 2 * int'(p.g) + int'(p.b);
        gv = 4'(s / 4);
        return {1'b1, gv, gv, gv};
      end
      2'd2: begin
        if (p.x != 10'd0) return {1'b1, p.r ^ 4'h5, p.g ^ 4'hA, p.b ^ 4'hF};
        return {1'b1, 12'h0};
      end
      default: return {1'b1, p.r, p.g, p.b};
    endcase
  endfunction

  // driver tasks
  task automatic drive_frame(input logic [1:0] mode, input logic mute, input logic fixed, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int line, px;
      raw_t p, h;
      logic [12:0] e;
      line = c / LINE_CYC;
      px   = c % LINE_CYC;
      p.de = (line < V) && (px < H);
      p.x  = 10'(px);
      if (fixed) begin
        p.r = 4'd4; p.g = 4'd8; p.b = 4'd4;
      end else begin
        p.r = 4'($urandom_range(0, 15));
        p.g = 4'($urandom_range(0, 15));
        p.b = 4'($urandom_range(0, 15));
      end
      de_in = p.de; x_in = p.x; y_in = 10'(line);
      r_in = p.r; g_in = p.g; b_in = p.b;
      if (hist.size() == LAT) begin
        h = hist[0];
        sobel_de = h.de && (h.x != 10'd0);
        sobel_r = h.r ^ 4'h5; sobel_g = h.g ^ 4'hA; sobel_b = h.b ^ 4'hF;
      end else begin
        sobel_de = 1'b0; sobel_r = 4'd0; sobel_g = 4'd0; sobel_b = 4'd0;
      end
      hist.push_back(p);
      if (hist.size() > LAT) h = hist.pop_front();
      exp_q.push_back(exp_pix(mode, mute, p));
      @(posedge clk); #1;
      if (exp_q.size() == LAT + 1) begin
        e = exp_q.pop_front();
        check("pix", {19'd0, de_out, r_out, g_out, b_out}, {19'd0, e});
      end
    end
  endtask

  task automatic cfg_send(input int offset, input logic [1:0] mode, input logic [7:0] th,
                          input logic [1:0] exp_pend);
    bit done;
    logic rdy;
    done = 1'b0;
    repeat (offset) begin @(posedge clk); #1; end
    cfg_valid = 1'b1; cfg_mode = mode; cfg_thresh = th;
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = cfg_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    cfg_valid = 1'b0;
    check("cfg_accept", 32'(done), 1);
    check("pend_state", dbg_state, 1);
    check("pend_busy", busy, 1);
    check("pend_mode", dbg_pend_mode, exp_pend);
  endtask

  task automatic btn_at(input int offset, input logic [1:0] exp_pend);
    repeat (offset) begin @(posedge clk); #1; end
    btn_mode = 1'b1;
    @(posedge clk); #1;
    check("btn_pend_mode", dbg_pend_mode, exp_pend);
    check("btn_state", dbg_state, 1);
    btn_mode = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic mute_probe(input int offset);
    repeat (offset) begin @(posedge clk); #1; end
    check("mute_cfg_ready", cfg_ready, 0);
    check("mute_busy", busy, 1);
    check("mute_state", dbg_state, 2);
  endtask

  typedef struct {
    logic [1:0] cfg_mode;
    logic [7:0] cfg_th;
    logic       fixed;
    logic [1:0] exp_mode;
    logic [7:0] exp_th;
    logic       exp_mute;
  } vec_t;

  vec_t vecs[3];
  logic [1:0] cur_mode;

  initial begin
    vecs[0] = '{cfg_mode: 2'd1, cfg_th: 8'd16, fixed: 1'b0, exp_mode: 2'd1, exp_th: 8'd16, exp_mute: 1'b0};
    vecs[1] = '{cfg_mode: 2'd2, cfg_th: 8'd40, fixed: 1'b1, exp_mode: 2'd2, exp_th: 8'd40, exp_mute: 1'b1};
    vecs[2] = '{cfg_mode: 2'd3, cfg_th: 8'd50, fixed: 1'b0, exp_mode: 2'd0, exp_th: 8'd50, exp_mute: 1'b0};

    reset = 1'b1; btn_mode = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_thresh = 8'd0;
    de_in = 1'b0; x_in = 10'd0; y_in = 10'd0; r_in = 4'd0; g_in = 4'd0; b_in = 4'd0;
    sobel_de = 1'b0; sobel_r = 4'd0; sobel_g = 4'd0; sobel_b = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mode", mode_active, 0);
    check("rst_th", th_edge, TH);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_pix", {de_out, r_out, g_out, b_out}, 0);

    drive_frame(2'd0, 1'b0, 1'b0, FRAME_CYC);
    drive_frame(2'd0, 1'b0, 1'b0, FRAME_CYC);
    check("idle_mode", mode_active, 0);
    check("idle_th", th_edge, TH);

    cur_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      fork
        drive_frame(cur_mode, 1'b0, vecs[i].fixed, FRAME_CYC);
        cfg_send(20, vecs[i].cfg_mode, vecs[i].cfg_th, vecs[i].exp_mode);
      join
      check("vec_mode", mode_active, vecs[i].exp_mode);
      check("vec_th", th_edge, vecs[i].exp_th);
      check("vec_state", dbg_state, vecs[i].exp_mute ? 2 : 0);
      check("vec_cfg_ready", cfg_ready, vecs[i].exp_mute ? 0 : 1);
      cur_mode = vecs[i].exp_mode;
      if (vecs[i].exp_mute) begin
        fork
          drive_frame(cur_mode, 1'b1, 1'b0, FRAME_CYC);
          mute_probe(10);
        join
        check("unmute_state", dbg_state, 0);
        check("unmute_busy", busy, 0);
        check("unmute_cfg_ready", cfg_ready, 1);
      end
    end

    // three button edges in one frame: 0 -> 1 -> 2 -> 0, no mute
    fork
      drive_frame(2'd0, 1'b0, 1'b0, FRAME_CYC);
      begin
        btn_at(5, 2'd1);
        btn_at(8, 2'd2);
        btn_at(8, 2'd0);
      end
    join
    check("btn3_mode", mode_active, 0);
    check("btn3_th", th_edge, 50);
    check("btn3_state", dbg_state, 0);

    // config and button edge in the same cycle: config wins, mode 3 coerced
    fork
      drive_frame(2'd0, 1'b0, 1'b0, FRAME_CYC);
      begin
        repeat (12) begin @(posedge clk); #1; end
        cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_thresh = 8'd99; btn_mode = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("both_pend_mode", dbg_pend_mode, 0);
        check("both_state", dbg_state, 1);
      end
    join
    check("both_th", th_edge, 99);
    check("both_mode", mode_active, 0);
    check("held_btn_state", dbg_state, 0);
    btn_mode = 1'b0;

    // request on the frame_end cycle stays pending for the following frame
    fork
      drive_frame(2'd0, 1'b0, 1'b0, FRAME_CYC);
      begin
        cfg_send(20, 2'd1, 8'd60, 2'd1);
        cfg_send(22, 2'd2, 8'd70, 2'd2);
      end
    join
    check("fe_mode", mode_active, 1);
    check("fe_th", th_edge, 60);
    check("fe_state", dbg_state, 1);
    check("fe_pend", dbg_pend_mode, 2);
    drive_frame(2'd1, 1'b0, 1'b0, FRAME_CYC);
    check("fe2_mode", mode_active, 2);
    check("fe2_th", th_edge, 70);
    check("fe2_state", dbg_state, 2);

    // reset in the middle of a muted frame
    drive_frame(2'd2, 1'b1, 1'b0, 20);
    check("pre_rst_cfg_ready", cfg_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_state", dbg_state, 0);
    check("mrst_mode", mode_active, 0);
    check("mrst_th", th_edge, TH);
    check("mrst_de_out", de_out, 0);
    check("mrst_cfg_ready", cfg_ready, 1);
    check("mrst_busy", busy, 0);
    reset = 1'b0;
    de_in = 1'b0;
    exp_q.delete();
    hist.delete();
    drive_frame(2'd0, 1'b0, 1'b0, FRAME_CYC);
    check("final_mode", mode_active, 0);
    check("final_state", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_mode_ctrl.md
# sobel_mode_ctrl

Frame-synchronous mode controller and output selector for the camera-to-VGA filter chain. It accepts mode changes from a push-button or a valid/ready config port and holds each request until the last active pixel of the current frame, so the mode never changes mid-frame. It mutes output for a programmable number of frames after entering Sobel mode, while the edge detector's line buffers refill. It also latency-aligns the raw pixel stream with the Sobel output and drives the final RGB to the VGA encoder.

## Interface
Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- SOBEL_LAT, 2, cycles from raw pixel in to Sobel output
- MUTE_FRAMES, 1, full frames blanked after switching into SOBEL (1..3)
- TH_DEFAULT, 16, edge threshold after reset

Ports:
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- btn_mode  in  1  debounced level; each rising edge is one "next mode" request
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept
- cfg_mode  in  2  0=BYPASS, 1=GRAY, 2=SOBEL, 3 coerced to BYPASS
- cfg_thresh  in  8  edge threshold, taken with cfg_mode
- de_in  in  1  raw stream data enable (same stream feeding Sobel)
- x_in, y_in  in  10 each  raw pixel coordinates
- r_in, g_in, b_in  in  4 each  raw pixel
- sobel_de  in  1  Sobel output enable
- sobel_r, sobel_g, sobel_b  in  4 each  Sobel output
- mode_active  out  2  mode currently applied
- th_edge  out  8  threshold currently applied
- busy  out  1  high in PEND or MUTE
- de_out  out  1  final enable
- r_out, g_out, b_out  out  4 each  final pixel

## Operation
- frame_end = de_in && x_in==H_RES-1 && y_in==V_RES-1.
- State machine, reset to RUN:
  - RUN: on an accepted request, load pend_mode and pend_th, then go to PEND.
  - PEND: a further request overwrites pend_mode and pend_th. On frame_end:
    - Load mode_active from pend_mode and th_edge from pend_th.
    - If the new mode is SOBEL and the old mode was not, load mute_cnt=MUTE_FRAMES and go to MUTE. Otherwise go to RUN.
  - MUTE: decrement mute_cnt on each frame_end. When a frame_end arrives with mute_cnt==1, go to RUN.
- Request sources:
  - Config: accepted when cfg_valid && cfg_ready. Sets pend_mode to cfg_mode (3 becomes 0) and pend_th to cfg_thresh.
  - Button: a rising edge, detected from a registered copy of btn_mode. Sets pend_mode = (base==2) ? 0 : base+1, where base is pend_mode in PEND and mode_active in RUN. pend_th = th_edge.
- cfg_ready = (state != MUTE). Button edges are dropped in MUTE.
- If a config handshake and a button edge occur in the same cycle, the config wins and the button edge is dropped.
- If a request and frame_end occur in the same cycle while in PEND, the previous pend_mode is applied this frame and the new request stays pending (state remains PEND).
- Output path:
  - The raw de, RGB, mode_active and a mute flag (state==MUTE) are delayed SOBEL_LAT cycles together through a shift pipeline. The mux always uses the delayed mode, so select changes land exactly on the frame boundary.
  - Mux, registered:
    - BYPASS: raw RGB.
    - GRAY: g4 = (r + 2g + b) >> 2, computed at 6 bits then truncated to 4; all channels = g4.
    - SOBEL: sobel RGB when sobel_de, else 0.
    - Delayed mute flag set: 0 on all channels.
  - de_out = delayed raw de (not sobel_de). RGB is 0 whenever delayed de is low.

## Timing
- Reset values: state=RUN, mode_active=0, th_edge=TH_DEFAULT, cfg_ready=1, busy=0, de_out=0, RGB=0, pipeline cleared, mute_cnt=0.
- Pixel latency: de_out/RGB appear SOBEL_LAT+1 cycles after the matching de_in.
- Config accept: pend values are visible in PEND the cycle after the handshake; busy=1 from that cycle.
- mode_active and th_edge update the cycle after frame_end. The first pixel of the following frame uses the new mode.
- Reset during PEND or MUTE discards the pending request; the next cycle is the RUN reset state.
- Holding btn_mode high counts as one request; it must fall and rise again for another.

## Test plan
- Reset, then drive 2 frames -> mode_active=0, th_edge=16, de_out lags de_in by 3 cycles, RGB equals raw input.
- cfg_mode=1 handshake mid-frame -> remaining pixels of that frame stay raw. The next frame outputs gray: r=4,g=8,b=4 gives 6 on all channels.
- cfg_mode=2, cfg_thresh=40, MUTE_FRAMES=1 -> th_edge=40 after frame_end. Next frame all RGB=0 with de_out toggling and cfg_ready=0. The frame after outputs Sobel pixels; busy=0.
- Three button edges in RUN within one frame -> pend_mode goes 1, 2, 0. At frame_end mode_active=0 and no MUTE.
- Config handshake and button edge in the same cycle, cfg_mode=3 -> pend_mode=0, button ignored.
- Reset asserted during MUTE -> next cycle state RUN, mode_active=0, de_out=0, cfg_ready=1.
